// File: rtl/tcpc_reset_ctrl_if.sv
// -----------------------------------------------------------------------------
// tcpc_reset_ctrl_if
// PHY reset-signalling handshake between the reset sequencer and the PHY.
//   phy_req   : level request, high while the PHY should signal the reset
//   phy_type  : 0 = Hard Reset, 1 = Cable Reset, stable while phy_req is high
//   phy_done  : one-cycle success pulse from the PHY
//   phy_fail  : one-cycle failure pulse from the PHY
// Handshake: the sequencer raises phy_req and holds it until the PHY answers
// with phy_done or phy_fail (sampled on the rising clock edge) or the
// per-attempt timeout expires; phy_req then drops on the following cycle.
// Pulses seen while phy_req is low are ignored.
// Modports: master = sequencer side, slave = PHY side.
// -----------------------------------------------------------------------------
interface tcpc_reset_ctrl_if;
    logic phy_req;
    logic phy_type;
    logic phy_done;
    logic phy_fail;

    modport master (
        output phy_req,
        output phy_type,
        input  phy_done,
        input  phy_fail
    );

    modport slave (
        input  phy_req,
        input  phy_type,
        output phy_done,
        output phy_fail
    );
endinterface

// File: rtl/tcpc_reset_ctrl.sv
// -----------------------------------------------------------------------------
// tcpc_reset_ctrl
// Hard/Cable Reset sequencer between the TCPC register block and the PHY.
// Decodes reset requests from TRANSMIT, runs up to MAX_RETRIES+1 attempts with
// a per-attempt timeout and a fixed backoff, discards requests that arrive
// while busy, and writes TRANSMIT/ALERT/RECEIVE_* values back.
//
// Optional feature macro: TCPC_CABLE_RESET_EN
//   defined   : TRANSMIT type 3'b110 runs a Cable Reset (phy_type = 1)
//   undefined : type 3'b110 is discarded and phy_type stays 0
//
// Ports:
//   CLK, reset              clock, asynchronous active-low reset
//   ioTRANSMIT              current TRANSMIT ([2:0] type, [5:4] retries)
//   iAlert                  current ALERT register
//   oTRANSMIT/_WE           TRANSMIT write-back value and one-cycle strobe
//   ALERT                   registered iAlert | event bits (6 ok, 4 fail, 5 discard)
//   oRECEIVE_DETECT,
//   oRECEIVE_BYTE_COUNT,
//   oRX_WE                  receive registers cleared at the start of a sequence
//   phy                     PHY request/done handshake (master side)
//   PHY_Stop_Attempting_Reset  retries exhausted, held until next accept
//   busy                    high in any non-IDLE state
//   dbg_state               current FSM state for observation
// -----------------------------------------------------------------------------
module tcpc_reset_ctrl #(
    parameter int DATA_W      = 8,
    parameter int ALERT_W     = 16,
    parameter int TIMER_W     = 16,
    parameter int TIMEOUT_CYC = 1000,
    parameter int BACKOFF_CYC = 16,
    parameter int MAX_RETRIES = 2
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic [DATA_W-1:0]    ioTRANSMIT,
    input  logic [ALERT_W-1:0]   iAlert,
    output logic [DATA_W-1:0]    oTRANSMIT,
    output logic                 oTRANSMIT_WE,
    output logic [ALERT_W-1:0]   ALERT,
    output logic [DATA_W-1:0]    oRECEIVE_DETECT,
    output logic [DATA_W-1:0]    oRECEIVE_BYTE_COUNT,
    output logic                 oRX_WE,
    tcpc_reset_ctrl_if.master    phy,
    output logic                 PHY_Stop_Attempting_Reset,
    output logic                 busy,
    output logic [2:0]           dbg_state
);
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CLEAR   = 3'd1;
    localparam logic [2:0] ST_SEND    = 3'd2;
    localparam logic [2:0] ST_WAIT    = 3'd3;
    localparam logic [2:0] ST_BACKOFF = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;
    localparam logic [2:0] ST_FAIL    = 3'd6;

    // Requested retries are a 2-bit field, so the cap never exceeds 3.
    localparam int          RETRY_CAP   = (MAX_RETRIES > 3) ? 3 : MAX_RETRIES;
    localparam logic [1:0]  RETRY_CAP_L = 2'(RETRY_CAP);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYC - 1);
    localparam logic [TIMER_W-1:0] BACKOFF_LAST = TIMER_W'(BACKOFF_CYC - 1);

    logic [2:0]         state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [1:0]         attempt_q, attempt_d;
    logic [1:0]         retries_q, retries_d;
    logic               type_q, type_d;
    logic               stop_q, stop_d;
    logic [DATA_W-1:0]  tx_q, tx_d;
    logic               tx_we_q, tx_we_d;
    logic               rx_we_q, rx_we_d;
    logic [ALERT_W-1:0] alert_q, alert_d;
    logic [ALERT_W-1:0] set_mask;

    logic [2:0] tx_type;
    logic       is_hard;
    logic       is_cable;
    logic       req_valid;
    logic       accept;
    logic       discard;
    logic [TIMER_W-1:0] timer_inc;

    assign tx_type  = ioTRANSMIT[2:0];
    assign is_hard  = (tx_type == 3'b101);
    assign is_cable = (tx_type == 3'b110);

`ifdef TCPC_CABLE_RESET_EN
    assign req_valid = is_hard | is_cable;
`else
    assign req_valid = is_hard;
`endif

    assign accept  = (state_q == ST_IDLE) && req_valid;
    // Any reset-type code that is not accepted gets the idle write-back so the
    // register block never presents it again.
    assign discard = (is_hard | is_cable) && !accept;

    // Saturating increment: the timer holds at all-ones instead of wrapping.
    assign timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        attempt_d = attempt_q;
        retries_d = retries_q;
        type_d    = type_q;
        stop_d    = stop_q;
        tx_d      = tx_q;
        tx_we_d   = 1'b0;
        rx_we_d   = 1'b0;
        set_mask  = '0;

        if (accept || discard) begin
            tx_d    = {ioTRANSMIT[DATA_W-1:3], 3'b111};
            tx_we_d = 1'b1;
        end
        if (discard) begin
            set_mask[5] = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_CLEAR;
                    retries_d = (ioTRANSMIT[5:4] > RETRY_CAP_L) ? RETRY_CAP_L
                                                                : ioTRANSMIT[5:4];
                    attempt_d = 2'd0;
                    stop_d    = 1'b0;
`ifdef TCPC_CABLE_RESET_EN
                    type_d    = is_cable;
`else
                    type_d    = 1'b0;
`endif
                end
            end
            ST_CLEAR: begin
                rx_we_d = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // phy_done has priority over a simultaneous phy_fail.
                if (phy.phy_done) begin
                    state_d = ST_DONE;
                end else if (phy.phy_fail || (timer_q == TIMEOUT_LAST)) begin
                    if (attempt_q < retries_q) begin
                        state_d = ST_BACKOFF;
                        timer_d = '0;
                    end else begin
                        state_d = ST_FAIL;
                    end
                end else begin
                    timer_d = timer_inc;
                end
            end
            ST_BACKOFF: begin
                if (timer_q == BACKOFF_LAST) begin
                    state_d   = ST_SEND;
                    attempt_d = attempt_q + 2'd1;
                end else begin
                    timer_d = timer_inc;
                end
            end
            ST_DONE: begin
                set_mask[6] = 1'b1;
                state_d     = ST_IDLE;
            end
            ST_FAIL: begin
                set_mask[4] = 1'b1;
                set_mask[5] = 1'b1;
                stop_d      = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        alert_d = iAlert | set_mask;
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            attempt_q <= 2'd0;
            retries_q <= 2'd0;
            type_q    <= 1'b0;
            stop_q    <= 1'b0;
            tx_q      <= '0;
            tx_we_q   <= 1'b0;
            rx_we_q   <= 1'b0;
            alert_q   <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            attempt_q <= attempt_d;
            retries_q <= retries_d;
            type_q    <= type_d;
            stop_q    <= stop_d;
            tx_q      <= tx_d;
            tx_we_q   <= tx_we_d;
            rx_we_q   <= rx_we_d;
            alert_q   <= alert_d;
        end
    end

    // phy_req is decoded from the state flop so an asynchronous reset drops it
    // immediately.
    assign phy.phy_req   = (state_q == ST_SEND) || (state_q == ST_WAIT);
    assign phy.phy_type  = type_q;

    assign oTRANSMIT                 = tx_q;
    assign oTRANSMIT_WE              = tx_we_q;
    assign ALERT                     = alert_q;
    assign oRECEIVE_DETECT           = '0;
    assign oRECEIVE_BYTE_COUNT       = '0;
    assign oRX_WE                    = rx_we_q;
    assign PHY_Stop_Attempting_Reset = stop_q;
    assign busy                      = (state_q != ST_IDLE);
    assign dbg_state                 = state_q;
endmodule

// File: tb/tb_tcpc_reset_ctrl.sv
module tb_tcpc_reset_ctrl;
    localparam int DW       = 8;
    localparam int AW       = 16;
    localparam int TIMEOUT  = 1000;
    localparam int BACKOFF  = 16;
    localparam int MAXR     = 2;

    // ---------------- clock / reset ----------------
    logic CLK   = 1'b0;
    logic reset = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    // ---------------- DUT ----------------
    logic [DW-1:0] tx_reg = 8'h07;
    logic [DW-1:0] ioTRANSMIT;
    logic [AW-1:0] iAlert = '0;
    logic [DW-1:0] oTRANSMIT;
    logic          oTRANSMIT_WE;
    logic [AW-1:0] ALERT;
    logic [DW-1:0] oRECEIVE_DETECT;
    logic [DW-1:0] oRECEIVE_BYTE_COUNT;
    logic          oRX_WE;
    logic          PHY_Stop_Attempting_Reset;
    logic          busy;
    logic [2:0]    dbg_state;

    tcpc_reset_ctrl_if phy_if();

    // Register block model: a write-back strobe overrides the stored value.
    assign ioTRANSMIT = oTRANSMIT_WE ? oTRANSMIT : tx_reg;

    tcpc_reset_ctrl #(
        .DATA_W(DW), .ALERT_W(AW), .TIMER_W(16),
        .TIMEOUT_CYC(TIMEOUT), .BACKOFF_CYC(BACKOFF), .MAX_RETRIES(MAXR)
    ) dut (
        .CLK                       (CLK),
        .reset                     (reset),
        .ioTRANSMIT                (ioTRANSMIT),
        .iAlert                    (iAlert),
        .oTRANSMIT                 (oTRANSMIT),
        .oTRANSMIT_WE              (oTRANSMIT_WE),
        .ALERT                     (ALERT),
        .oRECEIVE_DETECT           (oRECEIVE_DETECT),
        .oRECEIVE_BYTE_COUNT       (oRECEIVE_BYTE_COUNT),
        .oRX_WE                    (oRX_WE),
        .phy                       (phy_if),
        .PHY_Stop_Attempting_Reset (PHY_Stop_Attempting_Reset),
        .busy                      (busy),
        .dbg_state                 (dbg_state)
    );

    // ---------------- monitor ----------------
    int   rise_q[$];
    int   fall_q[$];
    logic req_prev = 1'b0;
    int   n_a6 = 0, n_a5 = 0, n_a4 = 0, n_twe = 0, n_rwe = 0;

    always @(negedge CLK) begin
        if (phy_if.phy_req && !req_prev) rise_q.push_back(cyc);
        if (!phy_if.phy_req && req_prev) fall_q.push_back(cyc);
        req_prev = phy_if.phy_req;
        if (ALERT[6])     n_a6++;
        if (ALERT[5])     n_a5++;
        if (ALERT[4])     n_a4++;
        if (oTRANSMIT_WE) n_twe++;
        if (oRX_WE)       n_rwe++;
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];   // expected phy_req window lengths

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge CLK);
        if (oTRANSMIT_WE) tx_reg = oTRANSMIT;
    endtask

    task automatic wait_req(input logic lvl, input int budget, input string tag);
        int n = 0;
        while (phy_if.phy_req !== lvl && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(phy_if.phy_req), 32'(lvl));
    endtask

    // PHY plan per attempt: 0 = done, 1 = fail, 2 = no answer, 3 = done+fail
    int plan_kind[3];
    int plan_dly[3];

    task automatic run_seq(input logic [7:0] tx, input int disc_at,
                           input logic exp_type, input string tag);
        int base_r, base_f, b6, b5, b4, bt, br, c0, retries, n_att, nr;
        bit succ;
        logic obs_type;
        logic [7:0] exp_tx;

        base_r = rise_q.size();
        base_f = fall_q.size();
        b6 = n_a6; b5 = n_a5; b4 = n_a4; bt = n_twe; br = n_rwe;

        // Reference model: attempts run until one succeeds or retries run out.
        retries = (int'(tx[5:4]) > MAXR) ? MAXR : int'(tx[5:4]);
        exp_q.delete();
        succ  = 0;
        n_att = 0;
        for (int a = 0; a <= retries; a++) begin
            n_att++;
            if (plan_kind[a] == 0 || plan_kind[a] == 3) begin
                exp_q.push_back(32'(plan_dly[a] + 1));
                succ = 1;
                break;
            end else if (plan_kind[a] == 1) begin
                exp_q.push_back(32'(plan_dly[a] + 1));
            end else begin
                exp_q.push_back(32'(TIMEOUT + 1));
            end
        end
        exp_tx = (disc_at > 0) ? 8'h07 : {tx[7:3], 3'b111};

        c0 = cyc;
        tx_reg = tx;
        obs_type = 1'b0;
        for (int a = 0; a < n_att; a++) begin
            wait_req(1'b1, 60, {tag, "_req_rise"});
            if (a == 0) obs_type = phy_if.phy_type;
            if (plan_kind[a] != 2) begin
                for (int k = 1; k <= plan_dly[a]; k++) begin
                    step();
                    if (a == 0 && k == disc_at) tx_reg = 8'h05;
                end
                phy_if.phy_done = (plan_kind[a] == 0 || plan_kind[a] == 3);
                phy_if.phy_fail = (plan_kind[a] == 1 || plan_kind[a] == 3);
                step();
                phy_if.phy_done = 1'b0;
                phy_if.phy_fail = 1'b0;
            end
            wait_req(1'b0, TIMEOUT + 100, {tag, "_req_fall"});
        end
        for (int n = 0; n < 40 && busy; n++) step();
        step();
        step();

        nr = rise_q.size() - base_r;
        check({tag, "_latency"}, (nr > 0) ? 32'(rise_q[base_r] - c0) : 32'hffff, 32'd2);
        check({tag, "_windows"}, 32'(nr), 32'(n_att));
        for (int a = 0; a < n_att; a++) begin
            if (nr > a && fall_q.size() > base_f + a)
                check($sformatf("%s_win%0d", tag, a),
                      32'(fall_q[base_f + a] - rise_q[base_r + a]), exp_q[a]);
            if (nr > a + 1 && fall_q.size() > base_f + a)
                check($sformatf("%s_gap%0d", tag, a),
                      32'(rise_q[base_r + a + 1] - fall_q[base_f + a]), 32'(BACKOFF));
        end
        check({tag, "_alert6"}, 32'(n_a6 - b6), 32'(succ));
        check({tag, "_alert4"}, 32'(n_a4 - b4), 32'(!succ));
        check({tag, "_alert5"}, 32'(n_a5 - b5), 32'(!succ) + ((disc_at > 0) ? 1 : 0));
        check({tag, "_tx_we"},  32'(n_twe - bt), (disc_at > 0) ? 32'd2 : 32'd1);
        check({tag, "_tx_val"}, 32'(oTRANSMIT), 32'(exp_tx));
        check({tag, "_rx_we"},  32'(n_rwe - br), 32'd1);
        check({tag, "_rx_val"}, 32'({oRECEIVE_DETECT, oRECEIVE_BYTE_COUNT}), 32'd0);
        check({tag, "_stop"},   32'(PHY_Stop_Attempting_Reset), 32'(!succ));
        check({tag, "_busy"},   32'(busy), 32'd0);
        check({tag, "_type"},   32'(obs_type), 32'(exp_type));
    endtask

    task automatic set_plan(input int k0, input int d0, input int k1, input int d1,
                            input int k2, input int d2);
        plan_kind[0] = k0; plan_dly[0] = d0;
        plan_kind[1] = k1; plan_dly[1] = d1;
        plan_kind[2] = k2; plan_dly[2] = d2;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int b5, bt, r;
        logic [AW-1:0] alert_val;
        logic [7:0] tx;

        phy_if.phy_done = 1'b0;
        phy_if.phy_fail = 1'b0;
        reset = 1'b0;
        repeat (3) step();
        check("rst_req",   32'(phy_if.phy_req), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_alert", 32'(ALERT), 32'd0);
        check("rst_tx",    32'({oTRANSMIT, 7'd0, oTRANSMIT_WE}), 32'd0);
        check("rst_stop",  32'(PHY_Stop_Attempting_Reset), 32'd0);
        reset = 1'b1;
        repeat (2) step();

        // Directed: single success, retry exhaustion, timeout, priority, discard, cap.
        set_plan(0, 3, 0, 1, 0, 1);  run_seq(8'h15, 0, 1'b0, "done3");
        set_plan(1, 5, 1, 5, 1, 5);  run_seq(8'h25, 0, 1'b0, "fail_all");
        set_plan(2, 1, 0, 1, 0, 1);  run_seq(8'h05, 0, 1'b0, "timeout");
        set_plan(3, 4, 0, 1, 0, 1);  run_seq(8'h05, 0, 1'b0, "both");
        set_plan(0, 8, 0, 1, 0, 1);  run_seq(8'h05, 3, 1'b0, "discard");
        set_plan(1, 2, 1, 7, 1, 3);  run_seq(8'h35, 0, 1'b0, "cap3");
        set_plan(1, 6, 0, 2, 0, 1);  run_seq(8'hD5, 0, 1'b0, "retry_ok");

        // Randomized sequences.
        for (int i = 0; i < 8; i++) begin
            for (int a = 0; a < 3; a++) begin
                r = $urandom_range(0, 15);
                plan_kind[a] = (r == 0) ? 2 : (r < 6) ? 0 : (r < 12) ? 1 : 3;
                plan_dly[a]  = $urandom_range(1, 12);
            end
            tx = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 3'b101};
            run_seq(tx, 0, 1'b0, $sformatf("rand%0d", i));
        end

        // Non-reset type code is ignored.
        bt = n_twe;
        tx_reg = 8'h03;
        repeat (4) step();
        check("ignore_we",   32'(n_twe - bt), 32'd0);
        check("ignore_busy", 32'(busy), 32'd0);
        tx_reg = 8'h07;
        step();

        // Cable Reset request.
`ifdef TCPC_CABLE_RESET_EN
        set_plan(0, 2, 0, 1, 0, 1);  run_seq(8'h06, 0, 1'b1, "cable");
`else
        bt = n_twe;
        b5 = n_a5;
        tx_reg = 8'h46;
        repeat (4) step();
        check("cable_we",    32'(n_twe - bt), 32'd1);
        check("cable_a5",    32'(n_a5 - b5), 32'd1);
        check("cable_tx",    32'(oTRANSMIT), 32'h47);
        check("cable_busy",  32'(busy), 32'd0);
        check("cable_type",  32'(phy_if.phy_type), 32'd0);
`endif

        // ALERT passes the register value through when no event is pending.
        alert_val = 16'($urandom) & 16'hFF8F;
        iAlert = alert_val;
        step();
        step();
        check("alert_pass", 32'(ALERT), 32'(alert_val));
        iAlert = '0;
        step();

        // Asynchronous reset in the middle of WAIT.
        tx_reg = 8'h15;
        wait_req(1'b1, 20, "arst_rise");
        step();
        step();
        #2;
        reset = 1'b0;
        #1;
        check("arst_req",   32'(phy_if.phy_req), 32'd0);
        check("arst_busy",  32'(busy), 32'd0);
        check("arst_tx",    32'(oTRANSMIT), 32'd0);
        check("arst_we",    32'({oTRANSMIT_WE, oRX_WE}), 32'd0);
        check("arst_alert", 32'(ALERT), 32'd0);
        check("arst_stop",  32'(PHY_Stop_Attempting_Reset), 32'd0);
        tx_reg = 8'h07;
        step();
        reset = 1'b1;
        repeat (3) step();
        check("arst_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
